// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch_stage signal bundle: redirect, decode and imem handshake (FETCH_MISALIGN_EN adds MisalignF)
interface fetch_stage_if;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_MISALIGN_EN
  logic        MisalignF;

  modport master (
    input  PCSrcE, PCTargetE, StallD, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD, MisalignF
  );

  modport slave (
    output PCSrcE, PCTargetE, StallD, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD, MisalignF
  );
`else
  modport master (
    input  PCSrcE, PCTargetE, StallD, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD
  );

  modport slave (
    output PCSrcE, PCTargetE, StallD, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, single-outstanding imem handshake, fetch buffer; optional FETCH_MISALIGN_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int               PTR_W    = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]       DEPTH_C  = 3'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;
`endif

  state_t           state_q, state_d;
  logic [31:0]      pcf_q, pcf_d;
  logic [31:0]      tag_q, tag_d;
  logic [31:0]      instr_buf_q [FIFO_DEPTH];
  logic [31:0]      pc_buf_q    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0]       count_q;

  logic        valid, push, pop, can_issue, req, accept, outstanding;
  logic [2:0]  occ_next;
  logic [31:0] target;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic halt_pend_q, halt_pend_d;
  logic misaligned;

  // Misaligned targets are kept intact so they can be detected
  assign target      = bus.PCTargetE;
  assign misaligned  = |bus.PCTargetE[1:0];
  assign outstanding = (state_q == S_WAIT) || (state_q == S_DROP) ||
                       ((state_q == S_HALT) && halt_pend_q);
`else
  assign target      = {bus.PCTargetE[31:2], 2'b00};
  assign outstanding = (state_q == S_WAIT) || (state_q == S_DROP);
`endif

  // Handshake and buffer control; a redirect suppresses push, pop and issue
  always_comb begin
    valid     = (count_q != 3'd0);
    pop       = valid && !bus.StallD && !bus.PCSrcE;
    push      = (state_q == S_WAIT) && bus.imem_rvalid && !bus.PCSrcE;
    can_issue = (state_q == S_FETCH) || ((state_q == S_WAIT) && bus.imem_rvalid);
    occ_next  = count_q + {2'b00, push} - {2'b00, pop};
    req       = !reset && !bus.PCSrcE && can_issue && (occ_next < DEPTH_C);
    accept    = req && bus.imem_ready;
  end

  // Next state, next PC and request tag
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    tag_d   = tag_q;
`ifdef FETCH_MISALIGN_EN
    misalign_d  = misalign_q;
    halt_pend_d = halt_pend_q;
`endif
    if (bus.PCSrcE) begin
      state_d = (outstanding && !bus.imem_rvalid) ? S_DROP : S_FETCH;
      pcf_d   = target;
`ifdef FETCH_MISALIGN_EN
      misalign_d  = misaligned;
      halt_pend_d = 1'b0;
      if (misaligned) begin
        // Remember an unanswered request so leaving HALT can still drop it
        state_d     = S_HALT;
        pcf_d       = pcf_q;
        halt_pend_d = outstanding && !bus.imem_rvalid;
      end
`endif
    end else begin
      if (accept) begin
        pcf_d = pcf_q + 32'd4;
        tag_d = pcf_q;
      end
      case (state_q)
        S_FETCH: if (accept) state_d = S_WAIT;
        S_WAIT:  if (bus.imem_rvalid) state_d = accept ? S_WAIT : S_FETCH;
        S_DROP:  if (bus.imem_rvalid) state_d = S_FETCH;
`ifdef FETCH_MISALIGN_EN
        S_HALT:  if (bus.imem_rvalid) halt_pend_d = 1'b0;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  // FSM, PC and tag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pcf_q   <= RESET_PC;
      tag_q   <= RESET_PC;
`ifdef FETCH_MISALIGN_EN
      misalign_q  <= 1'b0;
      halt_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      tag_q   <= tag_d;
`ifdef FETCH_MISALIGN_EN
      misalign_q  <= misalign_d;
      halt_pend_q <= halt_pend_d;
`endif
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
    end else if (bus.PCSrcE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      count_q <= occ_next;
    end
  end

  // Buffer storage; contents are only observed while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      instr_buf_q[wr_ptr_q] <= bus.imem_rdata;
      pc_buf_q[wr_ptr_q]    <= tag_q;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pcf_q;
  assign bus.ValidD    = valid;
  assign bus.InstrD    = valid ? instr_buf_q[rd_ptr_q] : NOP;
  assign bus.PCD       = valid ? pc_buf_q[rd_ptr_q] : 32'd0;
  assign bus.PCPlus4D  = valid ? pc_buf_q[rd_ptr_q] + 32'd4 : 32'd0;
`ifdef FETCH_MISALIGN_EN
  assign bus.MisalignF = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a random-latency imem and a stream model
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stream model: words reaching decode must be consecutive PCs from the last redirect
  int          exp_count;
  logic [31:0] exp_head_pc, exp_fetch_pc;
  int          epoch, mem_epoch, mem_left, pops;
  logic        mem_busy;
  logic [31:0] mem_addr;
  logic        prev_pend;
  logic [31:0] prev_addr;

  int          ready_pct, stall_pct, redir_pm, lat_min, lat_max;
  logic        force_stall, force_redir, force_ready0;
  logic [31:0] force_target;

  logic        s_valid, s_req, s_misalign;
  logic [31:0] s_pcd, s_instr, s_p4, s_addr, held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0;
    else t = $urandom_range(1023) * 4;
`ifndef FETCH_MISALIGN_EN
    t[1:0] = 2'($urandom_range(3));
`endif
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge
  task automatic step();
    logic deliver, acc, pop_m, good;
    deliver = mem_busy && (mem_left == 0);
    bus.imem_rvalid = deliver;
    bus.imem_rdata  = deliver ? mem_word(mem_addr) : $urandom;
    bus.imem_ready  = force_ready0 ? 1'b0 : ($urandom_range(99) < ready_pct);
    bus.StallD      = force_stall || ($urandom_range(99) < stall_pct);
    bus.PCSrcE      = force_redir || ($urandom_range(999) < redir_pm);
    bus.PCTargetE   = force_redir ? force_target : rand_target();
    #1;
    chk("ValidD", bus.ValidD, exp_count != 0);
    if (exp_count != 0) begin
      chk("PCD", bus.PCD, exp_head_pc);
      chk("InstrD", bus.InstrD, mem_word(exp_head_pc));
      chk("PCPlus4D", bus.PCPlus4D, exp_head_pc + 32'd4);
    end else begin
      chk("InstrD_nop", bus.InstrD, 32'h0000_0013);
      chk("PCD_zero", bus.PCD, 32'd0);
      chk("PCPlus4D_zero", bus.PCPlus4D, 32'd0);
    end
    if (bus.PCSrcE) chk("no_req_on_redirect", bus.imem_req, 1'b0);
    if (prev_pend && !bus.PCSrcE) begin
      chk("req_held", bus.imem_req, 1'b1);
      chk("addr_held", bus.imem_addr, prev_addr);
    end
    acc = bus.imem_req && bus.imem_ready;
    if (acc) begin
      chk("fetch_addr", bus.imem_addr, exp_fetch_pc);
      chk("one_outstanding", mem_busy && !deliver, 1'b0);
    end
    s_valid = bus.ValidD;
    s_req   = bus.imem_req;
    s_pcd   = bus.PCD;
    s_instr = bus.InstrD;
    s_p4    = bus.PCPlus4D;
    s_addr  = bus.imem_addr;
`ifdef FETCH_MISALIGN_EN
    s_misalign = bus.MisalignF;
`else
    s_misalign = 1'b0;
`endif
    pop_m     = (exp_count != 0) && !bus.StallD && !bus.PCSrcE;
    good      = deliver && (mem_epoch == epoch) && !bus.PCSrcE;
    prev_pend = bus.imem_req && !bus.imem_ready && !bus.PCSrcE;
    prev_addr = bus.imem_addr;
    @(posedge clk);
    if (deliver) mem_busy = 1'b0;
    else if (mem_busy) mem_left--;
    if (bus.PCSrcE) begin
      epoch++;
      exp_count    = 0;
      exp_head_pc  = align(bus.PCTargetE);
      exp_fetch_pc = align(bus.PCTargetE);
    end else begin
      exp_count = exp_count + (good ? 1 : 0) - (pop_m ? 1 : 0);
      if (pop_m) begin
        exp_head_pc = exp_head_pc + 32'd4;
        pops++;
      end
    end
    if (acc) begin
      mem_busy     = 1'b1;
      mem_addr     = s_addr;
      mem_epoch    = epoch;
      mem_left     = $urandom_range(lat_max, lat_min) - 1;
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    chk("occupancy_bound", exp_count <= DEPTH, 1'b1);
    @(negedge clk);
  endtask

  // Called at a negedge; memory resets with the block so nothing stays in flight
  task automatic do_reset();
    reset = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.imem_rdata  = 32'd0;
    bus.PCSrcE      = 1'b0;
    bus.PCTargetE   = 32'd0;
    bus.StallD      = 1'b0;
    exp_count = 0; exp_head_pc = 32'd0; exp_fetch_pc = 32'd0;
    mem_busy = 1'b0; mem_left = 0; epoch = 0; mem_epoch = 0; prev_pend = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.ValidD, 1'b0);
    chk("rst_instr", bus.InstrD, 32'h0000_0013);
    chk("rst_pcd", bus.PCD, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    ready_pct = 100; stall_pct = 0; redir_pm = 0; lat_min = 1; lat_max = 1;
    force_stall = 1'b0; force_redir = 1'b0; force_ready0 = 1'b0; force_target = 32'd0;
    pops = 0;
    @(negedge clk);
    do_reset();

    // First fetch latency, then imem_ready low for three cycles on address 0x8
    for (int k = 0; k < 8; k++) begin
      force_ready0 = (k >= 2) && (k <= 4);
      step();
      case (k)
        0: begin chk("t1_req0", s_req, 1'b1); chk("t1_addr0", s_addr, 32'h0); end
        1: chk("t1_valid_c1", s_valid, 1'b0);
        2: begin
          chk("t1_valid_c2", s_valid, 1'b1);
          chk("t1_pcd_c2", s_pcd, 32'h0);
          chk("t1_instr_c2", s_instr, 32'h0050_0093);
          chk("t3_addr_c2", s_addr, 32'h8);
        end
        3: begin
          chk("t1_pcd_c3", s_pcd, 32'h4);
          chk("t1_p4_c3", s_p4, 32'h8);
          chk("t1_instr_c3", s_instr, 32'h00A0_0113);
          chk("t3_addr_c3", s_addr, 32'h8);
        end
        4: begin chk("t3_addr_c4", s_addr, 32'h8); chk("t3_gap_c4", s_valid, 1'b0); end
        5: chk("t3_gap_c5", s_valid, 1'b0);
        6: chk("t3_gap_c6", s_valid, 1'b0);
        7: begin chk("t3_valid_c7", s_valid, 1'b1); chk("t3_pcd_c7", s_pcd, 32'h8); end
        default: ;
      endcase
    end
    force_ready0 = 1'b0;

    // Decode stall for five cycles fills the buffer and stops requests
    repeat (3) step();
    force_stall = 1'b1;
    step();
    held = s_pcd;
    chk("t2_valid", s_valid, 1'b1);
    repeat (4) step();
    chk("t2_held", s_pcd, held);
    chk("t2_req_off", s_req, 1'b0);
    chk("t2_fill", exp_count, 2);
    force_stall = 1'b0;
    repeat (10) step();

    // Redirect while 0xC is outstanding and its response is late, then redirect alongside rvalid
    do_reset();
    for (int k = 0; k < 18; k++) begin
      lat_min = (k == 3) ? 3 : 1;
      lat_max = lat_min;
      force_redir  = (k == 4) || (k == 14);
      force_target = (k == 4) ? 32'h100 : 32'h300;
      step();
      case (k)
        3:  chk("t4_addr_c", s_addr, 32'hC);
        4:  chk("t4_noreq", s_req, 1'b0);
        5:  begin chk("t4_empty", s_valid, 1'b0); chk("t4_drop_noreq5", s_req, 1'b0); end
        6:  chk("t4_drop_noreq6", s_req, 1'b0);
        7:  begin chk("t4_req_tgt", s_req, 1'b1); chk("t4_addr_tgt", s_addr, 32'h100); end
        9:  begin chk("t4_valid_tgt", s_valid, 1'b1); chk("t4_pcd_tgt", s_pcd, 32'h100); end
        15: chk("t5_gap1", s_valid, 1'b0);
        16: chk("t5_gap2", s_valid, 1'b0);
        17: begin chk("t5_valid_tgt", s_valid, 1'b1); chk("t5_pcd_tgt", s_pcd, 32'h300); end
        default: ;
      endcase
    end
    force_redir = 1'b0;

`ifdef FETCH_MISALIGN_EN
    force_redir = 1'b1; force_target = 32'h102;
    step();
    force_redir = 1'b0;
    repeat (4) begin
      step();
      chk("t6_misalign", s_misalign, 1'b1);
      chk("t6_halt_noreq", s_req, 1'b0);
    end
    force_redir = 1'b1; force_target = 32'h200;
    step();
    force_redir = 1'b0;
    step();
    chk("t6_misalign_clr", s_misalign, 1'b0);
    chk("t6_resume_req", s_req, 1'b1);
    chk("t6_resume_addr", s_addr, 32'h200);
`endif

    // Randomized traffic: imem back-pressure, latency, decode stalls and redirects
    pops = 0;
    for (int seg = 0; seg < 20; seg++) begin
      ready_pct = $urandom_range(100, 30);
      stall_pct = $urandom_range(60, 0);
      redir_pm  = $urandom_range(60, 0);
      lat_min   = 1;
      lat_max   = $urandom_range(4, 1);
      if (seg == 10) do_reset();
      repeat (200) step();
    end
    chk("progress", pops > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the decode stage and feeds the instruction word that the decode control logic consumes.
- Owns the PC register and talks to instruction memory through a request/response handshake with variable latency and at most one outstanding request.
- Buffers fetched words in a small FIFO so imem latency and decode stalls are decoupled.
- Squashes wrong-path fetches when execute redirects the PC on a taken branch, jal or jalr.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
FIFO_DEPTH, 2, fetch-buffer entries (allowed range 2..4)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
PCSrcE  in  1  redirect request from execute (taken branch/jump)
PCTargetE  in  32  redirect target address
StallD  in  1  decode cannot accept; hold current head
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address (PCF)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
InstrD  out  32  instruction to decode
PCD  out  32  PC of InstrD
PCPlus4D  out  32  PCD+4, mod 2^32
ValidD  out  1  InstrD holds a real instruction

Behaviour:
- Reset (async, immediate): PCF=RESET_PC; FIFO empty; state FETCH; imem_req=0 while reset is high; ValidD=0.
- Whenever ValidD=0, outputs are InstrD=32'h0000_0013 (nop), PCD=0 and PCPlus4D=0.
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: the outstanding request belongs to a squashed path.
- Issue rule: imem_req=1 when state is FETCH, or WAIT with imem_rvalid=1, and (count+push−pop) < FIFO_DEPTH.
  - Acceptance = imem_req & imem_ready. On acceptance, the {PCF, pc} tag is recorded, PCF += 4 (wraps), and the next state is WAIT.
  - An unaccepted request keeps imem_addr stable. It may only be withdrawn on redirect.
- WAIT: imem_rvalid pushes {tag, imem_rdata}. Without a same-cycle reissue the next state is FETCH; with one it stays WAIT.
- DROP: imem_rvalid is discarded and the next state is FETCH. No new request is issued in DROP.
- Any imem_rvalid while state is FETCH is ignored.
- Decode side: head of the FIFO drives InstrD/PCD/PCPlus4D combinationally; ValidD = !empty. Pop when ValidD & !StallD.
- Simultaneous push and pop in the same cycle keeps count; full and empty are exact.
- Redirect (PCSrcE=1) has highest priority:
  - FIFO cleared at the edge; pop and push that cycle are ignored.
  - PCF <= PCTargetE.
  - Outstanding request with no rvalid this cycle: next state DROP. Otherwise next state FETCH.
  - No request is issued in the redirect cycle.
- Latency with a 1-cycle imem (ready=1, rvalid the cycle after acceptance):
  - First ValidD is 2 cycles after reset deassertion.
  - Steady state is 1 instr/cycle with StallD=0.
  - Redirect to first target instruction at decode is 3 cycles.
- Instruction memory is reset together with this block; no response arrives for a pre-reset request.

Optional Feature:
FETCH_MISALIGN_EN
- Defined:
  - Adds output MisalignF (1 bit, reset 0).
  - A redirect with PCTargetE[1:0]!=0 sets MisalignF=1, clears the FIFO and enters a HALT state. In HALT, imem_req=0 and outstanding responses are dropped.
  - Only a later aligned redirect or reset leaves HALT; either one clears MisalignF.
- Undefined: PCTargetE[1:0] is forced to 2'b00 on load, and no HALT state or MisalignF port exists.

Test Plan:
- Reset release, imem ready=1, 1-cycle rvalid, StallD=0, mem[0]=0x00500093, mem[4]=0x00A00113 -> ValidD rises at cycle 2 with PCD=0 and InstrD=0x00500093; next cycle PCD=4 and PCPlus4D=8.
- StallD=1 for 5 cycles in steady stream -> InstrD/PCD held; FIFO fills to 2; imem_req drops; no word lost or duplicated after release.
- imem_ready low 3 cycles with imem_addr=0x8 -> address held stable; PCF advances only on acceptance; ValidD gap of 3 cycles.
- PCSrcE=1, PCTargetE=0x100 while a request to 0xC is outstanding (rvalid delayed 2 cycles) -> 0xC response discarded (DROP); FIFO empty; next accepted imem_addr=0x100; first valid PCD=0x100.
- PCSrcE=1 in the same cycle as imem_rvalid and StallD=0 -> neither the response nor the popped head survives; next ValidD shows the target PC.
- With FETCH_MISALIGN_EN: PCTargetE=0x102 -> MisalignF=1, imem_req=0 indefinitely; then PCTargetE=0x200 -> MisalignF=0 and fetch resumes at 0x200.
